// File: rtl/max_pool_forward.sv
// Streaming lane-wise max-pool over POOL_SIZE consecutive float vectors.
// Floats are compared through a monotonic unsigned key, so NaN/zero ordering is
// fully defined: +NaN above everything, -NaN below everything, +0 above -0.
// Optional feature macro: MAX_POOL_ARGMAX_EN adds out_idx (winning beat per lane).
module max_pool_forward #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned POOL_SIZE = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        clk_en,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data [WIDTH-1:0],
  input  logic [31:0] in_id,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data [WIDTH-1:0],
  output logic [31:0] out_id
`ifdef MAX_POOL_ARGMAX_EN
  ,
  output logic [$clog2(POOL_SIZE)-1:0] out_idx [WIDTH-1:0]
`endif
);

  localparam int unsigned CntW = $clog2(POOL_SIZE);
  localparam logic [CntW-1:0] LastBeat = CntW'(POOL_SIZE - 1);

  typedef enum logic [0:0] {StAccum, StHold} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [31:0]     acc_q [WIDTH-1:0];
  logic [31:0]     acc_d [WIDTH-1:0];
  logic [31:0]     id_q, id_d;
  logic            out_valid_q, out_valid_d;
  logic [31:0]     out_data_q [WIDTH-1:0];
  logic [31:0]     out_data_d [WIDTH-1:0];
  logic [31:0]     out_id_q, out_id_d;
  logic [31:0]     merged [WIDTH-1:0];
  logic            beat_acc, consume;
`ifdef MAX_POOL_ARGMAX_EN
  logic [CntW-1:0] idx_q [WIDTH-1:0];
  logic [CntW-1:0] idx_d [WIDTH-1:0];
  logic [CntW-1:0] out_idx_q [WIDTH-1:0];
  logic [CntW-1:0] out_idx_d [WIDTH-1:0];
  logic [CntW-1:0] merged_idx [WIDTH-1:0];
`endif

  // Monotonic key: unsigned compare of keys matches float ordering.
  function automatic logic [31:0] float_key(input logic [31:0] x);
    return x[31] ? ~x : (x ^ 32'h8000_0000);
  endfunction

  // Handshake qualifiers; HOLD only takes a beat when the pending output leaves.
  always_comb begin
    in_ready  = clk_en && ((state_q == StAccum) || out_ready);
    beat_acc  = in_valid && in_ready;
    consume   = out_valid_q && out_ready && clk_en;
    out_valid = out_valid_q;
    out_id    = out_id_q;
    out_data  = out_data_q;
`ifdef MAX_POOL_ARGMAX_EN
    out_idx   = out_idx_q;
`endif
  end

  // Per-lane merge of the incoming beat into the accumulator; beat 0 always loads,
  // and a strictly larger key is required to replace, so ties keep the earlier beat.
  always_comb begin
    for (int k = 0; k < int'(WIDTH); k++) begin
      merged[k] = acc_q[k];
`ifdef MAX_POOL_ARGMAX_EN
      merged_idx[k] = idx_q[k];
`endif
      if ((cnt_q == '0) || (float_key(in_data[k]) > float_key(acc_q[k]))) begin
        merged[k] = in_data[k];
`ifdef MAX_POOL_ARGMAX_EN
        merged_idx[k] = cnt_q;
`endif
      end
    end
  end

  // Next-state: window accumulation, output hold and zero-bubble restart.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    id_d        = id_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_id_d    = out_id_q;
`ifdef MAX_POOL_ARGMAX_EN
    idx_d       = idx_q;
    out_idx_d   = out_idx_q;
`endif
    case (state_q)
      StAccum: begin
        if (beat_acc) begin
          acc_d = merged;
`ifdef MAX_POOL_ARGMAX_EN
          idx_d = merged_idx;
`endif
          if (cnt_q == '0) id_d = in_id;
          if (cnt_q == LastBeat) begin
            out_data_d  = merged;
            out_id_d    = id_q;
            out_valid_d = 1'b1;
`ifdef MAX_POOL_ARGMAX_EN
            out_idx_d   = merged_idx;
`endif
            cnt_d       = '0;
            state_d     = StHold;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
      end
      StHold: begin
        if (consume) begin
          out_valid_d = 1'b0;
          state_d     = StAccum;
          // A beat accepted alongside the consume opens the next window.
          if (beat_acc) begin
            acc_d = merged;
            id_d  = in_id;
`ifdef MAX_POOL_ARGMAX_EN
            idx_d = merged_idx;
`endif
            cnt_d = CntW'(1);
          end
        end
      end
      default: state_d = StAccum;
    endcase
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StAccum;
      cnt_q       <= '0;
      id_q        <= '0;
      out_valid_q <= 1'b0;
      out_id_q    <= '0;
      for (int k = 0; k < int'(WIDTH); k++) begin
        acc_q[k]      <= '0;
        out_data_q[k] <= '0;
`ifdef MAX_POOL_ARGMAX_EN
        idx_q[k]      <= '0;
        out_idx_q[k]  <= '0;
`endif
      end
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      id_q        <= id_d;
      out_valid_q <= out_valid_d;
      out_id_q    <= out_id_d;
      acc_q       <= acc_d;
      out_data_q  <= out_data_d;
`ifdef MAX_POOL_ARGMAX_EN
      idx_q       <= idx_d;
      out_idx_q   <= out_idx_d;
`endif
    end
  end

endmodule

// File: tb/tb_max_pool_forward.sv
// Directed self-checking bench for max_pool_forward (WIDTH=8, POOL_SIZE=4).
// Inputs are driven and outputs sampled around the falling clock edge.
module tb_max_pool_forward;

  localparam int unsigned W = 8;
  localparam int unsigned P = 4;

  logic        clk;
  logic        reset_n;
  logic        clk_en;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data [W-1:0];
  logic [31:0] in_id;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data [W-1:0];
  logic [31:0] out_id;
`ifdef MAX_POOL_ARGMAX_EN
  logic [1:0]  out_idx [W-1:0];
`endif

  max_pool_forward #(
    .WIDTH     (W),
    .POOL_SIZE (P)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .clk_en    (clk_en),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_id     (in_id),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_id    (out_id)
`ifdef MAX_POOL_ARGMAX_EN
    ,
    .out_idx   (out_idx)
`endif
  );

  always #5 clk = ~clk;

  // Stimulus windows [window][beat][lane] and hand-derived results [window][lane].
  logic [31:0] win      [3][4][W];
  logic [31:0] exp_data [3][W];
  int          exp_idx  [3][W];

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic set_lane(input int w, input int k, input logic [31:0] v0, input logic [31:0] v1,
                          input logic [31:0] v2, input logic [31:0] v3, input logic [31:0] e,
                          input int ix);
    win[w][0][k] = v0;
    win[w][1][k] = v1;
    win[w][2][k] = v2;
    win[w][3][k] = v3;
    exp_data[w][k] = e;
    exp_idx[w][k]  = ix;
  endtask

  task automatic drive_inputs(input int w, input int b, input logic [31:0] id);
    in_valid = 1'b1;
    in_id    = id;
    for (int k = 0; k < int'(W); k++) in_data[k] = win[w][b][k];
  endtask

  task automatic drive_beat(input int w, input int b, input logic [31:0] id);
    drive_inputs(w, b, id);
    @(negedge clk);
  endtask

  task automatic check_window(input int w, input logic [31:0] id, input string tag);
    check_eq({tag, "_valid"}, {31'b0, out_valid}, 32'd1);
    for (int k = 0; k < int'(W); k++) begin
      check_eq($sformatf("%s_data%0d", tag, k), out_data[k], exp_data[w][k]);
`ifdef MAX_POOL_ARGMAX_EN
      check_eq($sformatf("%s_idx%0d", tag, k), {30'b0, out_idx[k]}, exp_idx[w][k]);
`endif
    end
    check_eq({tag, "_id"}, out_id, id);
  endtask

  initial begin
    clk       = 1'b0;
    reset_n   = 1'b0;
    clk_en    = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_id     = '0;
    for (int k = 0; k < int'(W); k++) in_data[k] = '0;

    // Window A: ordering corner cases, one per lane.
    set_lane(0, 0, 32'h3F800000, 32'h40000000, 32'hBF800000, 32'h3F000000, 32'h40000000, 1);
    set_lane(0, 1, 32'hC0000000, 32'hBF800000, 32'h80000000, 32'h00000000, 32'h00000000, 3);
    set_lane(0, 2, 32'h80000000, 32'h80000000, 32'h80000000, 32'h80000000, 32'h80000000, 0);
    set_lane(0, 3, 32'h3F800000, 32'h40000000, 32'h7FC00000, 32'h3F800000, 32'h7FC00000, 2);
    set_lane(0, 4, 32'hBF800000, 32'hFFC00000, 32'hBF800000, 32'hBF800000, 32'hBF800000, 0);
    set_lane(0, 5, 32'h00000000, 32'h80000000, 32'h00000000, 32'h80000000, 32'h00000000, 0);
    set_lane(0, 6, 32'h80000000, 32'h00000000, 32'h80000000, 32'h00000000, 32'h00000000, 1);
    set_lane(0, 7, 32'hFF800000, 32'h7F800000, 32'h7FC00000, 32'h3F800000, 32'h7FC00000, 2);
    // Window B: max on the last beat; window C: max tied between beats 0 and 3.
    for (int k = 0; k < int'(W); k++) begin
      set_lane(1, k, 32'h41000000 + k, 32'h41100000 + k, 32'h40800000 + k, 32'h41200000 + k,
               32'h41200000 + k, 3);
      set_lane(2, k, 32'h42000000 + k, 32'h3F800000, 32'hC2000000, 32'h42000000 + k,
               32'h42000000 + k, 0);
    end

    // Reset values.
    @(negedge clk);
    check_eq("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check_eq("rst_out_id", out_id, 32'd0);
    check_eq("rst_out_data0", out_data[0], 32'd0);
    check_eq("rst_in_ready", {31'b0, in_ready}, 32'd1);
    reset_n = 1'b1;
    @(negedge clk);

    // Window A, later beats carry different ids that must not be captured.
    for (int b = 0; b < 3; b++) drive_beat(0, b, 32'hA000_0001 + b);
    check_eq("a_early_valid", {31'b0, out_valid}, 32'd0);
    drive_beat(0, 3, 32'hDEAD_0000);
    in_valid = 1'b0;
    check_window(0, 32'hA000_0001, "a");

    // Backpressure: output held, input stalled while out_ready is low.
    drive_inputs(1, 0, 32'hB000_0002);
    for (int c = 0; c < 5; c++) begin
      #1;
      check_eq($sformatf("bp_in_ready%0d", c), {31'b0, in_ready}, 32'd0);
      @(negedge clk);
      check_eq($sformatf("bp_data%0d", c), out_data[0], 32'h40000000);
      check_eq($sformatf("bp_id%0d", c), out_id, 32'hA000_0001);
    end
    out_ready = 1'b1;
    #1;
    check_eq("bp_release_ready", {31'b0, in_ready}, 32'd1);
    @(negedge clk);
    check_eq("bp_consumed", {31'b0, out_valid}, 32'd0);
    for (int b = 1; b < 4; b++) drive_beat(1, b, 32'h5555_0000 + b);
    in_valid = 1'b0;
    check_window(1, 32'hB000_0002, "b");

    // Zero-bubble: consume B and take C beat 0 on the same edge.
    drive_beat(2, 0, 32'hC000_0003);
    check_eq("zb_consumed", {31'b0, out_valid}, 32'd0);
    drive_beat(2, 1, 32'h6666_0001);

    // clk_en low mid-window: nothing accepted.
    clk_en = 1'b0;
    drive_inputs(2, 2, 32'h6666_0002);
    for (int c = 0; c < 3; c++) begin
      #1;
      check_eq($sformatf("ce_in_ready%0d", c), {31'b0, in_ready}, 32'd0);
      @(negedge clk);
      check_eq($sformatf("ce_valid%0d", c), {31'b0, out_valid}, 32'd0);
    end
    clk_en = 1'b1;
    drive_beat(2, 2, 32'h6666_0002);
    check_eq("ce_not_done", {31'b0, out_valid}, 32'd0);
    drive_beat(2, 3, 32'h6666_0003);
    in_valid = 1'b0;
    check_window(2, 32'hC000_0003, "c");

    // clk_en low in HOLD: no consume despite out_ready.
    clk_en = 1'b0;
    @(negedge clk);
    check_eq("hold_ce_valid", {31'b0, out_valid}, 32'd1);
    check_eq("hold_ce_data", out_data[3], 32'h42000003);
    clk_en = 1'b1;
    @(negedge clk);
    check_eq("hold_consumed", {31'b0, out_valid}, 32'd0);

    // Reset mid-window, then a fresh window must be unaffected.
    out_ready = 1'b0;
    for (int b = 0; b < 3; b++) drive_beat(1, b, 32'hD000_0004);
    in_valid = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    check_eq("mid_rst_valid", {31'b0, out_valid}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    for (int b = 0; b < 3; b++) drive_beat(0, b, 32'hE000_0005 + b);
    check_eq("post_rst_early", {31'b0, out_valid}, 32'd0);
    drive_beat(0, 3, 32'h0);
    in_valid = 1'b0;
    check_window(0, 32'hE000_0005, "post_rst");

    // Reset while holding an output discards it immediately.
    #2 reset_n = 1'b0;
    #1;
    check_eq("hold_rst_valid", {31'b0, out_valid}, 32'd0);
    check_eq("hold_rst_data", out_data[0], 32'd0);
    check_eq("hold_rst_id", out_id, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check_eq("hold_rst_after", {31'b0, out_valid}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
